serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 5 +
 rtl/full_subtractor_using_hs.sv | 15 +
 rtl/serial_subtractor.sv | 96 +++++++++
 tb/tb_serial_subtractor.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encoding and default width for the serial subtractor
package serial_subtractor_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/full_subtractor_using_hs.sv
// full_subtractor_using_hs: one-bit full subtractor built from two half-subtractor stages
module full_subtractor_using_hs (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);
    logic d1, b1, b2;
    assign d1   = A ^ B;
    assign b1   = ~A & B;
    assign Diff = d1 ^ Bin;
    assign b2   = ~d1 & Bin;
    assign Bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial unsigned subtractor with start/valid handshake
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, dsh_q, dsh_d, dsh_next;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d, bout_q, bout_d;
    logic             cell_diff, cell_bout, accept, last;

    full_subtractor_using_hs u_cell (
        .A   (a_sh_q[0]),
        .B   (b_sh_q[0]),
        .Bin (br_q),
        .Diff(cell_diff),
        .Bout(cell_bout)
    );

    assign accept   = start && (state_q != S_SHIFT);
    assign last     = (cnt_q == CW'(WIDTH - 1));
    assign dsh_next = (dsh_q >> 1) | (WIDTH'(cell_diff) << (WIDTH - 1));
    assign ready    = (state_q != S_SHIFT);
    assign busy     = (state_q == S_SHIFT);
    assign valid    = (state_q == S_DONE);
    assign diff     = diff_q;
    assign bout     = bout_q;

    // Load operands on accept, otherwise step one bit per SHIFT edge and publish on the last bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        dsh_d   = dsh_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        if (accept) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            a_sh_d  = a;
            b_sh_d  = b;
            dsh_d   = '0;
            br_d    = bin;
        end else if (state_q == S_SHIFT) begin
            cnt_d   = cnt_q + 1'b1;
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            dsh_d   = dsh_next;
            br_d    = cell_bout;
            state_d = last ? S_DONE : S_SHIFT;
            diff_d  = last ? dsh_next : diff_q;
            bout_d  = last ? cell_bout : bout_q;
        end
    end

    // State registers; reset overrides any pending start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            dsh_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            dsh_q   <= dsh_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table-driven and scoreboarded checks of the serial subtractor
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst, start, bin;
    logic [7:0] a, b, diff;
    logic       ready, busy, valid, bout;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       bo;
    } exp_t;

    vec_t vecs[6];
    exp_t sbq[$];
    int   total = 0;
    int   passed = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .ready(ready),
        .busy (busy),
        .valid(valid),
        .diff (diff),
        .bout (bout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({name, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk({name, " diff"}, 32'(diff), 32'(e.d));
            chk({name, " bout"}, 32'(bout), 32'(e.bo));
            chk({name, " ready"}, 32'(ready), 32'd1);
            chk({name, " busy"}, 32'(busy), 32'd0);
        end
    endtask

    // Drive one operation with a one-cycle start, optionally pulsing start again mid-SHIFT
    task automatic run(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       input logic [7:0] ed, input logic eb, input int pulse_at, input string name);
        int n;
        exp_t e;
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        e.d = ed; e.bo = eb;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({name, " busy after accept"}, 32'(busy), 32'd1);
        n = 0;
        while (!valid && n < 20) begin
            if (n == pulse_at) begin
                start = 1'b1; a = 8'hFF; b = 8'h00;
            end else start = 1'b0;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, " latency"}, 32'(n), 32'd8);
        pop_check(name);
    endtask

    initial begin
        int n, bad;
        exp_t e;
        logic [8:0] m;
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[4] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
        vecs[5] = '{8'h33, 8'h33, 1'b0, 8'h00, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset diff", 32'(diff), 32'd0);
        chk("reset bout", 32'(bout), 32'd0);
        // reset beats a simultaneous start
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset vs start busy", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 6; i++)
            run(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, -1, $sformatf("vec%0d", i));

        for (int i = 0; i < 4; i++) begin
            logic [7:0] ra, rb;
            logic       rbi;
            ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
            m = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
            run(ra, rb, rbi, m[7:0], m[8], -1, $sformatf("rand%0d", i));
        end

        // DONE holds with no start
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("done hold valid", 32'(valid), 32'd1);

        run(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 3, "busy ignore");

        // back-to-back with start held high
        @(negedge clk);
        a = 8'h09; b = 8'h03; bin = 1'b0; start = 1'b1;
        e.d = 8'h06; e.bo = 1'b0; sbq.push_back(e);
        e.d = 8'hFA; e.bo = 1'b1; sbq.push_back(e);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!valid && n < 20);
        chk("b2b first latency", 32'(n), 32'd9);
        pop_check("b2b first");
        a = 8'h03; b = 8'h09;
        n = 0; bad = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!valid && diff !== 8'h06) bad++;
        end while (!valid && n < 20);
        chk("b2b valid low cycles", 32'(n - 1), 32'd8);
        chk("b2b diff stable", 32'(bad), 32'd0);
        start = 1'b0;
        pop_check("b2b second");

        // reset in the middle of SHIFT
        @(negedge clk);
        a = 8'h44; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("midop busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midop ready", 32'(ready), 32'd1);
        chk("midop busy", 32'(busy), 32'd0);
        chk("midop valid", 32'(valid), 32'd0);
        chk("midop diff", 32'(diff), 32'd0);
        chk("midop bout", 32'(bout), 32'd0);
        run(8'h44, 8'h11, 1'b0, 8'h33, 1'b0, -1, "after reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
